procyon_mul_fu: RTL
===================

PROCYON_MUL_FU -- requirements
Module: procyon_mul_fu

Interface
REQ-001 SHALL have parameter OPTN_DATA_WIDTH, default 32, operand/result width; must be even.
REQ-002 SHALL have parameter OPTN_ROB_IDX_WIDTH, default 5, ROB tag width.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port i_flush  input  1  pipeline flush.
REQ-006 SHALL have port i_fu_valid  input  1  reservation station issue valid.
REQ-007 SHALL have port i_fu_op  input  pcyn_op_t  operation.
REQ-008 SHALL have port i_fu_src[0:1]  input  OPTN_DATA_WIDTH each  source operands (rs1, rs2).
REQ-009 SHALL have port i_fu_tag  input  OPTN_ROB_IDX_WIDTH  destination ROB tag.
REQ-010 SHALL have port o_fu_stall  output  1  back-pressure to the reservation station.
REQ-011 SHALL have port o_cdb_en  output  1  CDB broadcast valid.
REQ-012 SHALL have port o_cdb_data  output  OPTN_DATA_WIDTH  CDB result.
REQ-013 SHALL have port o_cdb_tag  output  OPTN_ROB_IDX_WIDTH  CDB tag.

Function
REQ-014 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE; state, operands, 2W accumulator, iteration counter, sign flag, tag all registered.
REQ-015 SHALL drive o_fu_stall = (state != IDLE), decoded from the state register only; no combinational path from i_fu_valid.
REQ-016 SHALL accept an op when state is IDLE, i_fu_valid=1 and i_flush=0: capture operands/op/tag, load counter with N, enter BUSY next cycle.
REQ-017 SHALL ignore i_fu_valid in BUSY and DONE; the reservation station holds the op while o_fu_stall=1.
REQ-018 SHALL, with N = OPTN_DATA_WIDTH (radix-2), retire one multiplier bit per BUSY cycle; BUSY lasts exactly N cycles, then DONE.
REQ-019 SHALL compute on magnitudes: operands treated as signed are absolute-valued at accept; product negated (two's complement, 2W bits) at DONE entry when exactly one signed operand was negative.
REQ-020 SHALL select result: PCYN_OP_MUL low W bits; PCYN_OP_MULH high W, signed x signed; PCYN_OP_MULHSU high W, src0 signed x src1 unsigned; PCYN_OP_MULHU high W, unsigned x unsigned.
REQ-021 SHALL treat any other accepted op as producing o_cdb_data=0 with identical latency.
REQ-022 SHALL assert o_cdb_en = (state==DONE) & ~i_flush for exactly one cycle, with o_cdb_data/o_cdb_tag valid that cycle; latency accept cycle T -> o_cdb_en at T+N+1.
REQ-023 SHALL return to IDLE the cycle after DONE; o_fu_stall low at T+N+2, next op acceptable then.
REQ-024 SHALL on i_flush=1 in any state go to IDLE next cycle, suppress any broadcast, and not accept an op that cycle.
REQ-025 SHALL hold o_cdb_data and o_cdb_tag stable outside DONE (last value).

Reset
REQ-026 SHALL on n_rst=0 asynchronously set state IDLE, o_fu_stall=0, o_cdb_en=0, o_cdb_data=0, o_cdb_tag=0, counter/accumulator 0.
REQ-027 SHALL abandon any in-flight op on reset mid-BUSY/DONE; no broadcast after reset release until a new accept.

Configuration
REQ-028 SHALL, when PCYN_MUL_RADIX4_EN is defined, retire two multiplier bits per BUSY cycle (N = OPTN_DATA_WIDTH/2, latency T+N+1); results bit-identical.
REQ-029 SHALL, when PCYN_MUL_RADIX4_EN is undefined, use radix-2 with N = OPTN_DATA_WIDTH.

Verification (W=32)
REQ-030 SHALL cover: MUL 3 x 5 accepted at T -> o_cdb_en=1 only at T+33, data 0x0000000F, tag echoed; 1-cycle pulse (T+17 with PCYN_MUL_RADIX4_EN).
REQ-031 SHALL cover: MULH 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF; MUL 0x80000000 x 0xFFFFFFFF -> 0x80000000.
REQ-032 SHALL cover: second i_fu_valid held from T+1 -> o_fu_stall=1 T+1..T+33, second op accepted at T+34, broadcast at T+67.
REQ-033 SHALL cover: i_flush at T+10 -> o_cdb_en never asserts for that op, o_fu_stall=0 at T+11; flush coincident with DONE -> o_cdb_en=0.
REQ-034 SHALL cover: n_rst low at T+5 -> all outputs 0 immediately, no broadcast after release; then MUL 7 x 6 -> 0x0000002A at normal latency.

Source files
------------

// File: rtl/procyon_mul_fu_if.sv
// Operation encoding and the issue/CDB bundle of the Procyon iterative multiplier.
// master = reservation station / CDB side, slave = the multiply unit.
package pcyn_pkg;
    typedef enum logic [3:0] {
        PCYN_OP_MUL    = 4'd0,
        PCYN_OP_MULH   = 4'd1,
        PCYN_OP_MULHSU = 4'd2,
        PCYN_OP_MULHU  = 4'd3,
        PCYN_OP_ADD    = 4'd4,
        PCYN_OP_SUB    = 4'd5
    } pcyn_op_t;
endpackage

interface procyon_mul_fu_if #(
    parameter int OPTN_DATA_WIDTH    = 32,
    parameter int OPTN_ROB_IDX_WIDTH = 5
);
    import pcyn_pkg::*;

    // Issue: the RS holds i_fu_* stable while o_fu_stall is high; an op is taken
    // on a rising edge where i_fu_valid=1, o_fu_stall=0 and i_flush=0.
    // CDB: o_cdb_data/o_cdb_tag are meaningful only in the cycle o_cdb_en=1.
    logic                          i_flush;
    logic                          i_fu_valid;
    pcyn_op_t                      i_fu_op;
    logic [OPTN_DATA_WIDTH-1:0]    i_fu_src [0:1];
    logic [OPTN_ROB_IDX_WIDTH-1:0] i_fu_tag;
    logic                          o_fu_stall;
    logic                          o_cdb_en;
    logic [OPTN_DATA_WIDTH-1:0]    o_cdb_data;
    logic [OPTN_ROB_IDX_WIDTH-1:0] o_cdb_tag;
    logic [1:0]                    fu_state;

    modport master (
        output i_flush, i_fu_valid, i_fu_op, i_fu_src, i_fu_tag,
        input  o_fu_stall, o_cdb_en, o_cdb_data, o_cdb_tag, fu_state
    );

    modport slave (
        input  i_flush, i_fu_valid, i_fu_op, i_fu_src, i_fu_tag,
        output o_fu_stall, o_cdb_en, o_cdb_data, o_cdb_tag, fu_state
    );
endinterface

// File: rtl/procyon_mul_fu.sv
// Iterative shift-add multiplier (RV32M MUL/MULH/MULHSU/MULHU) broadcasting on the CDB.
// Define PCYN_MUL_RADIX4_EN to retire two multiplier bits per cycle instead of one.
module procyon_mul_fu #(
    parameter int OPTN_DATA_WIDTH    = 32,
    parameter int OPTN_ROB_IDX_WIDTH = 5
) (
    input  logic             clk,
    input  logic             n_rst,
    procyon_mul_fu_if.slave  fu
);
    import pcyn_pkg::*;

    localparam int W  = OPTN_DATA_WIDTH;
    localparam int W2 = 2 * OPTN_DATA_WIDTH;
    localparam int R  = OPTN_ROB_IDX_WIDTH;
`ifdef PCYN_MUL_RADIX4_EN
    localparam int N  = W / 2;
`else
    localparam int N  = W;
`endif
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W2-1:0]   mcand;
    logic [W2-1:0]   acc;
    logic [W-1:0]    mplier;
    logic [CW-1:0]   count;
    logic            negate;
    pcyn_op_t        op;
    logic [R-1:0]    tag;
    logic [W-1:0]    cdb_data;
    logic [R-1:0]    cdb_tag;

    logic            src0_signed;
    logic            src1_signed;
    logic            src0_neg;
    logic            src1_neg;
    logic [W-1:0]    mag0;
    logic [W-1:0]    mag1;
    logic [W2-1:0]   pp;
    logic [W2-1:0]   mcand_next;
    logic [W-1:0]    mplier_next;
    logic [W2-1:0]   acc_sum;
    logic [W2-1:0]   product;
    logic [W-1:0]    result;

    // Operand conditioning at accept: signed sources are reduced to magnitudes.
    always_comb begin
        src0_signed = (fu.i_fu_op == PCYN_OP_MULH) || (fu.i_fu_op == PCYN_OP_MULHSU);
        src1_signed = (fu.i_fu_op == PCYN_OP_MULH);
        src0_neg    = src0_signed && fu.i_fu_src[0][W-1];
        src1_neg    = src1_signed && fu.i_fu_src[1][W-1];
        mag0        = src0_neg ? (~fu.i_fu_src[0] + W'(1)) : fu.i_fu_src[0];
        mag1        = src1_neg ? (~fu.i_fu_src[1] + W'(1)) : fu.i_fu_src[1];
    end

    always_comb begin
`ifdef PCYN_MUL_RADIX4_EN
        pp          = (mplier[0] ? mcand : '0) +
                      (mplier[1] ? {mcand[W2-2:0], 1'b0} : '0);
        mcand_next  = {mcand[W2-3:0], 2'b00};
        mplier_next = {2'b00, mplier[W-1:2]};
`else
        pp          = mplier[0] ? mcand : '0;
        mcand_next  = {mcand[W2-2:0], 1'b0};
        mplier_next = {1'b0, mplier[W-1:1]};
`endif
        acc_sum     = acc + pp;
        // Sign is restored on the final sum as the FSM enters DONE.
        product     = negate ? (~acc_sum + W2'(1)) : acc_sum;
        case (op)
            PCYN_OP_MUL:    result = product[W-1:0];
            PCYN_OP_MULH,
            PCYN_OP_MULHSU,
            PCYN_OP_MULHU:  result = product[W2-1:W];
            default:        result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            mcand    <= '0;
            acc      <= '0;
            mplier   <= '0;
            count    <= '0;
            negate   <= 1'b0;
            op       <= PCYN_OP_MUL;
            tag      <= '0;
            cdb_data <= '0;
            cdb_tag  <= '0;
        end else if (fu.i_flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (fu.i_fu_valid) begin
                        mcand  <= {{W{1'b0}}, mag0};
                        mplier <= mag1;
                        acc    <= '0;
                        count  <= CW'(N);
                        negate <= src0_neg ^ src1_neg;
                        op     <= fu.i_fu_op;
                        tag    <= fu.i_fu_tag;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    mcand  <= mcand_next;
                    mplier <= mplier_next;
                    count  <= count - CW'(1);
                    if (count == CW'(1)) begin
                        acc      <= product;
                        cdb_data <= result;
                        cdb_tag  <= tag;
                        state    <= DONE;
                    end else begin
                        acc <= acc_sum;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign fu.o_fu_stall = (state != IDLE);
    assign fu.o_cdb_en   = (state == DONE) & ~fu.i_flush;
    assign fu.o_cdb_data = cdb_data;
    assign fu.o_cdb_tag  = cdb_tag;
    assign fu.fu_state   = state;
endmodule
